// File: rtl/alu_unit.sv
// alu_unit: multicycle RV32I execute unit.
// The unit answers the alu_en / alu_valid handshake. Shifts run one bit per
// cycle, and branch_op gives the branch condition combinationally.
// Optional macro ALU_FAST_SHIFT_EN: when defined, shifts use a barrel
// shifter and finish in one cycle like the other ops. SHIFT is then never
// entered and alu_busy is tied low.
module alu_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_en,
  input  logic [4:0]       alu_op,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_valid,
  output logic             alu_busy,
  output logic [2:0]       branch_op
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_e;
  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_e;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_ADDR = 5'b11000;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SRA  = 5'b10000;
  localparam logic [4:0] OP_SLT  = 5'b10001;
  localparam logic [4:0] OP_SLTU = 5'b10010;

  state_e             state_q, state_d;
  shift_kind_e        kind_q, kind_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               valid_q, busy_q;

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   op_result;
  logic [WIDTH-1:0]   work_step;

  assign shamt    = operand_b[SHAMT_W-1:0];
  assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

  // Single-cycle result for the op presented on the request edge.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    op_result = '0;
    case (alu_op)
      OP_ADD, OP_ADDR: op_result = operand_a + operand_b;
      OP_SUB:          op_result = operand_a - operand_b;
      OP_AND:          op_result = operand_a & operand_b;
      OP_OR:           op_result = operand_a | operand_b;
      OP_XOR:          op_result = operand_a ^ operand_b;
      OP_SLT:          op_result = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU:         op_result = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:          op_result = operand_a << shamt;
      OP_SRL:          op_result = operand_a >> shamt;
      OP_SRA:          op_result = WIDTH'($signed(operand_a) >>> shamt);
`endif
      default:         op_result = '0;
    endcase
  end

  // One-bit step of the working register for the latched shift kind.
  always_comb begin
    case (kind_q)
      SK_SLL:  work_step = {work_q[WIDTH-2:0], 1'b0};
      SK_SRL:  work_step = {1'b0, work_q[WIDTH-1:1]};
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and datapath update for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    result_d = result_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (alu_en) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            work_d  = operand_a;
            cnt_d   = shamt;
            kind_d  = (alu_op == OP_SLL) ? SK_SLL :
                      (alu_op == OP_SRL) ? SK_SRL : SK_SRA;
            state_d = SHIFT;
          end else if (is_shift) begin
            result_d = operand_a;
            state_d  = DONE;
          end else
`endif
          begin
            result_d = op_result;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = work_step;
          state_d  = DONE;
        end
      end
      DONE:    state_d = alu_en ? HOLD : IDLE;
      default: state_d = alu_en ? HOLD : IDLE;
    endcase
  end

  // State and output registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= SK_SLL;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q  <= state_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      valid_q  <= (state_d == DONE);
      busy_q   <= (state_d == SHIFT);
    end
  end

  assign alu_result = result_q;
  assign alu_valid  = valid_q;
`ifdef ALU_FAST_SHIFT_EN
  assign alu_busy   = 1'b0;
`else
  assign alu_busy   = busy_q;
`endif

  // Branch condition code from the operands and func3.
  always_comb begin
    branch_op = 3'b000;
    case (func3)
      3'b000: if (operand_a == operand_b)                   branch_op = 3'b001;
      3'b001: if (operand_a != operand_b)                   branch_op = 3'b010;
      3'b100: if ($signed(operand_a) <  $signed(operand_b)) branch_op = 3'b011;
      3'b101: if ($signed(operand_a) >= $signed(operand_b)) branch_op = 3'b100;
      3'b110: if (operand_a <  operand_b)                   branch_op = 3'b101;
      3'b111: if (operand_a >= operand_b)                   branch_op = 3'b110;
      default:                                              branch_op = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: a directed vector table plus a
// mid-shift reset sequence.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_en = 1'b0;
  logic [4:0]  alu_op = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] alu_result;
  logic        alu_valid;
  logic        alu_busy;
  logic [2:0]  branch_op;

  int total = 0;
  int bad   = 0;

  alu_unit dut (
    .clk(clk), .rst(rst), .alu_en(alu_en), .alu_op(alu_op), .func3(func3),
    .operand_a(operand_a), .operand_b(operand_b), .alu_result(alu_result),
    .alu_valid(alu_valid), .alu_busy(alu_busy), .branch_op(branch_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [31:0] exp_res;
    int          exp_lat;   // iterative-shift latency
    int          exp_busy;  // iterative-shift busy cycles
    logic        shift;
    logic [2:0]  exp_br;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Apply one request, hold alu_en through valid and one more cycle, then drop.
  task automatic run_vec(input vec_t v);
    int lat;
    int busy_cnt;
    int want_lat;
    int want_busy;
    bit seen;
    want_lat  = v.exp_lat;
    want_busy = v.exp_busy;
`ifdef ALU_FAST_SHIFT_EN
    if (v.shift) begin
      want_lat  = 1;
      want_busy = 0;
    end
`endif
    operand_a = v.a;
    operand_b = v.b;
    alu_op    = v.op;
    func3     = v.f3;
    alu_en    = 1'b1;
    #1;
    check("branch_op", 32'(branch_op), 32'(v.exp_br));
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (alu_valid) seen = 1'b1;
      else if (alu_busy) busy_cnt++;
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(want_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(want_busy));
    check("result", alu_result, v.exp_res);
    @(posedge clk); #1;
    check("no_second_pulse", 32'(alu_valid), 32'd0);
    alu_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("valid_after_drop", 32'(alu_valid), 32'd0);
    check("result_held", alu_result, v.exp_res);
  endtask

  vec_t vecs[14];

  initial begin
    int lat;
    bit seen;
    //          op        a             b             f3      result        lat busy sh  br
    vecs[0]  = '{5'b00001, 32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000000, 1,  0,  0, 3'b011};
    vecs[1]  = '{5'b00011, 32'h00000005, 32'h00000007, 3'b000, 32'hFFFFFFFE, 1,  0,  0, 3'b000};
    vecs[2]  = '{5'b01101, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'h0FF00FF0, 1,  0,  0, 3'b010};
    vecs[3]  = '{5'b10000, 32'h80000000, 32'd31,       3'b110, 32'hFFFFFFFF, 32, 31, 1, 3'b000};
    vecs[4]  = '{5'b01110, 32'h12345678, 32'h00000020, 3'b111, 32'h12345678, 1,  0,  1, 3'b110};
    vecs[5]  = '{5'b11000, 32'h00001000, 32'h00000024, 3'b010, 32'h00001024, 1,  0,  0, 3'b000};
    vecs[6]  = '{5'b10001, 32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h00000001, 1,  0,  0, 3'b000};
    vecs[7]  = '{5'b10010, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000000, 1,  0,  0, 3'b110};
    vecs[8]  = '{5'b01100, 32'h0000AAAA, 32'h0000AAAA, 3'b000, 32'h0000AAAA, 1,  0,  0, 3'b001};
    vecs[9]  = '{5'b01111, 32'h80000000, 32'd4,        3'b101, 32'h08000000, 5,  4,  1, 3'b000};
    vecs[10] = '{5'b01110, 32'h00000001, 32'd3,        3'b100, 32'h00000008, 4,  3,  1, 3'b011};
    vecs[11] = '{5'b00000, 32'h00000005, 32'h00000005, 3'b101, 32'h00000000, 1,  0,  0, 3'b100};
    vecs[12] = '{5'b10000, 32'hF0000000, 32'h00000024, 3'b011, 32'hFF000000, 5,  4,  1, 3'b000};
    vecs[13] = '{5'b01010, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1,  0,  0, 3'b000};

    // Reset state
    #12;
    check("rst_result", alu_result, 32'h0);
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_busy", 32'(alu_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a long shift
    operand_a = 32'h80000000;
    operand_b = 32'd31;
    alu_op    = 5'b10000;
    alu_en    = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midshift_rst_result", alu_result, 32'h0);
    check("midshift_rst_valid", 32'(alu_valid), 32'd0);
    check("midshift_rst_busy", 32'(alu_busy), 32'd0);
    alu_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (alu_valid) seen = 1'b1;
    end
    check("no_valid_after_rst", 32'(seen), 32'd0);

    // First request after reset release: ADD 1+1
    operand_a = 32'd1;
    operand_b = 32'd1;
    alu_op    = 5'b00001;
    alu_en    = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (alu_valid) seen = 1'b1;
    end
    alu_en = 1'b0;
    check("post_rst_valid", 32'(seen), 32'd1);
    check("post_rst_latency", 32'(lat), 32'd1);
    check("post_rst_add", alu_result, 32'd2);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
